// File: rtl/pipeline_regfile.sv
// rtl/pipeline_regfile.sv - MIPS architectural register file with write-through ID read ports
module pipeline_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_07FC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WrReg,
  input  logic [DATA_W-1:0] WrData,
  input  logic [ADDR_W-1:0] RdReg1,
  input  logic [ADDR_W-1:0] RdReg2,
  output logic [DATA_W-1:0] RdData1,
  output logic [DATA_W-1:0] RdData2,
  input  logic [ADDR_W-1:0] DbgReg,
  output logic [DATA_W-1:0] DbgData,
  output logic [15:0]       WrCount
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SP_IDX = 29;

  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              wr_en;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  logic [DATA_W-1:0] stored_dbg;

  // Register 0 is never written and never stored; gating here keeps it out of every path.
  assign wr_en = RegWrite && !reset && (WrReg != '0);

  always_comb begin
    wr_count_d = wr_count_q;
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      wr_count_d = wr_count_q + 16'd1;
      for (int i = 1; i < DEPTH; i++) begin
        if (WrReg == ADDR_W'(i)) regs_d[i] = WrData;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_q <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      wr_count_q <= wr_count_d;
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    stored1    = '0;
    stored2    = '0;
    stored_dbg = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (RdReg1 == ADDR_W'(i)) stored1 = regs_q[i];
      if (RdReg2 == ADDR_W'(i)) stored2 = regs_q[i];
      if (DbgReg == ADDR_W'(i)) stored_dbg = regs_q[i];
    end
  end

  // Same-cycle WB data is forwarded to ID; debug view shows committed state only.
  assign RdData1 = (wr_en && (WrReg == RdReg1)) ? WrData : stored1;
  assign RdData2 = (wr_en && (WrReg == RdReg2)) ? WrData : stored2;
  assign DbgData = stored_dbg;
  assign WrCount = wr_count_q;

endmodule

// File: tb/tb_pipeline_regfile.sv
// tb/tb_pipeline_regfile.sv - scoreboard bench for pipeline_regfile
module tb_pipeline_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WrReg;
  logic [31:0] WrData;
  logic [4:0]  RdReg1;
  logic [4:0]  RdReg2;
  logic [31:0] RdData1;
  logic [31:0] RdData2;
  logic [4:0]  DbgReg;
  logic [31:0] DbgData;
  logic [15:0] WrCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  pipeline_regfile dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WrReg(WrReg), .WrData(WrData),
    .RdReg1(RdReg1), .RdReg2(RdReg2), .RdData1(RdData1), .RdData2(RdData2),
    .DbgReg(DbgReg), .DbgData(DbgData), .WrCount(WrCount)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input string tag, input logic [4:0] idx, input logic [31:0] val);
    DbgReg = idx;
    expect_val(tag, val);
    #1;
    observe({16'h0, 16'h0} | DbgData);
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WrReg = '0; WrData = '0;
    RdReg1 = '0; RdReg2 = '0; DbgReg = '0;
    #2;
    dbg_check("rst_sp", 5'd29, 32'h0000_07FC);
    dbg_check("rst_r5", 5'd5, 32'h0);
    expect_val("rst_cnt", 32'h0);
    observe({16'h0, WrCount});

    // Write attempted while reset is held: no bypass, no commit.
    RegWrite = 1'b1; WrReg = 5'd7; WrData = 32'h0000_0077; RdReg1 = 5'd7;
    expect_val("rst_nobypass", 32'h0);
    #1;
    observe(RdData1);
    tick();
    dbg_check("rst_edge_nowrite", 5'd7, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    dbg_check("first_write_after_rst", 5'd7, 32'h0000_0077);
    expect_val("cnt_after_first", 32'd1);
    observe({16'h0, WrCount});

    // Write/read of reg 8.
    WrReg = 5'd8; WrData = 32'hDEAD_BEEF;
    tick();
    RegWrite = 1'b0;
    RdReg1 = 5'd8;
    expect_val("rd1_r8", 32'hDEAD_BEEF);
    expect_val("cnt_r8", 32'd2);
    #1;
    observe(RdData1);
    observe({16'h0, WrCount});

    // Dual-port bypass to reg 31.
    DbgReg = 5'd31;
    RegWrite = 1'b1; WrReg = 5'd31; WrData = 32'h0040_0010; RdReg1 = 5'd31; RdReg2 = 5'd31;
    expect_val("byp_rd1", 32'h0040_0010);
    expect_val("byp_rd2", 32'h0040_0010);
    expect_val("byp_dbg_old", 32'h0);
    #1;
    observe(RdData1);
    observe(RdData2);
    observe(DbgData);
    tick();
    RegWrite = 1'b0;
    dbg_check("byp_dbg_new", 5'd31, 32'h0040_0010);
    expect_val("cnt_byp", 32'd3);
    observe({16'h0, WrCount});

    // Register 0 writes are discarded.
    RegWrite = 1'b1; WrReg = 5'd0; WrData = 32'hFFFF_FFFF; RdReg2 = 5'd0;
    expect_val("r0_before", 32'h0);
    #1;
    observe(RdData2);
    tick();
    RegWrite = 1'b0;
    expect_val("r0_after", 32'h0);
    expect_val("cnt_r0", 32'd3);
    #1;
    observe(RdData2);
    observe({16'h0, WrCount});
    dbg_check("r0_dbg", 5'd0, 32'h0);

    // Enable low: no bypass, no state change, don't-care address/data.
    RegWrite = 1'b1; WrReg = 5'd26; WrData = 32'h1111_2222;
    tick();
    RegWrite = 1'b0; WrData = 32'hA5A5_A5A5; RdReg1 = 5'd26;
    expect_val("en_low_rd1", 32'h1111_2222);
    #1;
    observe(RdData1);
    tick();
    WrReg = 'x; WrData = 'x;
    tick();
    dbg_check("en_low_dbg", 5'd26, 32'h1111_2222);
    expect_val("en_low_cnt", 32'd4);
    observe({16'h0, WrCount});

    // Asynchronous reset mid-cycle after writing reg 5.
    RegWrite = 1'b1; WrReg = 5'd5; WrData = 32'h0000_1234;
    tick();
    RegWrite = 1'b0;
    dbg_check("r5_written", 5'd5, 32'h0000_1234);
    #1;
    reset = 1'b1;
    #1;
    dbg_check("async_r5", 5'd5, 32'h0);
    dbg_check("async_sp", 5'd29, 32'h0000_07FC);
    dbg_check("async_r8", 5'd8, 32'h0);
    expect_val("async_cnt", 32'h0);
    observe({16'h0, WrCount});
    tick();
    reset = 1'b0;

    // Counter wrap on 65536 writes to reg 3.
    RegWrite = 1'b1; WrReg = 5'd3;
    for (int i = 1; i <= 65535; i++) begin
      WrData = 32'(i);
      tick();
    end
    expect_val("cnt_ffff", 32'h0000_FFFF);
    observe({16'h0, WrCount});
    WrData = 32'h0001_0000;
    tick();
    RegWrite = 1'b0;
    expect_val("cnt_wrap", 32'h0);
    observe({16'h0, WrCount});
    dbg_check("wrap_r3", 5'd3, 32'h0001_0000);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_regfile.md
Name: pipeline_regfile

Overview:
- Architectural register file of the 5-stage MIPS pipeline; the receiving end of the write-back interface.
- The WB stage supplies a write-enable, destination register (WB_Destiny) and write data (WB_out).
- The ID stage reads two source operands combinationally, with write-through bypass, so a same-cycle WB write is visible to ID without a separate WB→ID forward.
- A third read port serves the debug/display logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W = 32.
- SP_INIT, 32'h0000_07FC, reset value of register 29 ($sp); all other registers reset to 0.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears/initialises all registers.
- RegWrite  input  1  write enable from WB stage.
- WrReg  input  ADDR_W  destination index from WB stage (e.g. 31 for jal, 26 for exception PC save).
- WrData  input  DATA_W  write data from WB stage.
- RdReg1  input  ADDR_W  ID-stage source index rs.
- RdReg2  input  ADDR_W  ID-stage source index rt.
- RdData1  output  DATA_W  operand for rs.
- RdData2  output  DATA_W  operand for rt.
- DbgReg  input  ADDR_W  debug read index.
- DbgData  output  DATA_W  debug read value; no bypass.
- WrCount  output  16  number of committed writes to nonzero registers since reset.

Behaviour:
- Storage: 31 physical registers, 1..31. Register 0 has no storage; reads of index 0 always return 0.
- Reset (asynchronous, immediate, independent of clk):
  - registers 1..28 and 30..31 = 0; register 29 = SP_INIT; WrCount = 0.
  - While reset is high, writes are ignored and read ports return reset contents; RdData* is not bypassed, since RegWrite is ignored.
- Write:
  - On posedge clk with reset low, RegWrite=1 and WrReg≠0: reg[WrReg] <= WrData, and WrCount increments by 1 (wraps 16'hFFFF → 0).
  - RegWrite=1 with WrReg=0: no state change, WrCount unchanged.
  - Latency: new value observable on DbgData the cycle after the edge.
- Read ports 1/2: purely combinational, zero latency.
  - If RegWrite=1, reset low, WrReg≠0 and WrReg==RdRegN: RdDataN = WrData (write-through bypass).
  - Otherwise RdDataN = stored value, or 0 for index 0.
  - Both ports may address the same register; both may bypass in the same cycle.
- Debug port: DbgData = stored value only (0 for index 0); never bypassed.
- Write during reset deassertion: an edge while reset is still high performs no write. The first write occurs on the first edge with reset low.
- X-safety: with RegWrite=0, WrReg/WrData values are don't-care and must not affect state or outputs.

Test Plan:
- Reset: assert reset mid-run after writing reg 5=32'h1234 → DbgData(5)=0, DbgData(29)=32'h7FC, WrCount=0 immediately, without waiting for a clk edge.
- Write/read: write reg 8=32'hDEADBEEF, then read RdReg1=8 next cycle → RdData1=32'hDEADBEEF; WrCount=1.
- Bypass: in the same cycle, RegWrite=1, WrReg=31, WrData=32'h0040_0010, RdReg1=RdReg2=31 → both RdData=32'h0040_0010 before the edge; DbgData(31) old value until after the edge.
- Zero register: write reg 0=32'hFFFFFFFF with RdReg2=0 → RdData2=0 before and after; WrCount unchanged.
- Enable low: RegWrite=0, WrReg=26, WrData=32'hA5A5A5A5 → reg 26 unchanged, no bypass on RdData1 with RdReg1=26.
- Counter wrap: 65536 writes to reg 3 → WrCount returns to 0; reg 3 holds the last data written.
